// File: rtl/stage_if_if.sv
// Byte-wide shared memory read port between the instruction-fetch stage and memory.
// The master side issues requests; the slave side returns grant and read data.
interface stage_if_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic [7:0]  mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_gnt,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_gnt,
        output mem_data
    );
endinterface

// File: rtl/stage_if.sv
// RV32I instruction-fetch stage: assembles 32-bit words from a byte-wide shared memory port,
// steers the PC on decode redirects. Define ICACHE_EN to add a direct-mapped instruction cache.
module stage_if #(
    parameter int unsigned ICACHE_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_enable_i,
    input  logic [31:0] branch_addr_i,
    stage_if_if.master  mem,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        inst_valid_o
);
    typedef enum logic [1:0] {StReq, StDrain, StPresent} state_e;

    state_e      r_state, w_state_d;
    logic [31:0] r_fetch_pc, w_fetch_pc_d;
    logic [2:0]  r_issue_cnt, w_issue_cnt_d;
    logic [2:0]  r_recv_cnt, w_recv_cnt_d;
    logic        r_pending, w_pending_d;
    logic        r_run;
    logic [31:0] r_inst_buf, w_inst_buf_d;
    logic [31:0] r_pc, w_pc_d;
    logic [31:0] r_inst, w_inst_d;
    logic        r_valid, w_valid_d;
    logic        w_redirect, w_hit, w_fill;
    logic [31:0] w_hit_data;
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_unused_addr;

    assign w_unused_addr = ^branch_addr_i[1:0];

`ifdef ICACHE_EN
    localparam int unsigned Idx  = $clog2(ICACHE_ENTRIES);
    localparam int unsigned TagW = 30 - Idx;

    logic [31:0]               r_cache_data [ICACHE_ENTRIES];
    logic [TagW-1:0]           r_cache_tag  [ICACHE_ENTRIES];
    logic [ICACHE_ENTRIES-1:0] r_cache_valid;
    logic [Idx-1:0]            w_idx;
    logic [TagW-1:0]           w_tag;

    assign w_idx      = r_fetch_pc[2+Idx-1:2];
    assign w_tag      = r_fetch_pc[31:2+Idx];
    assign w_hit      = r_cache_valid[w_idx] && (r_cache_tag[w_idx] == w_tag);
    assign w_hit_data = r_cache_data[w_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cache_valid <= '0;
        end else if (w_fill) begin
            r_cache_valid[w_idx] <= 1'b1;
        end
    end

    // Storage is not reset; a line is only read once its valid bit is set.
    always_ff @(posedge clk) begin
        if (w_fill) begin
            r_cache_data[w_idx] <= w_inst_d;
            r_cache_tag[w_idx]  <= w_tag;
        end
    end
`else
    logic w_unused_cfg;

    assign w_hit        = 1'b0;
    assign w_hit_data   = '0;
    assign w_unused_cfg = ^{ICACHE_ENTRIES, w_fill};
`endif

    always_comb begin
        w_state_d     = r_state;
        w_fetch_pc_d  = r_fetch_pc;
        w_issue_cnt_d = r_issue_cnt;
        w_recv_cnt_d  = r_recv_cnt;
        w_pending_d   = 1'b0;
        w_inst_buf_d  = r_inst_buf;
        w_pc_d        = r_pc;
        w_inst_d      = r_inst;
        w_valid_d     = r_valid;
        w_fill        = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_addr    = r_fetch_pc + {29'd0, r_issue_cnt};
        w_redirect    = branch_enable_i && !stall_i;

        // Data returns one cycle after a granted request.
        if (r_pending) begin
            w_inst_buf_d[8*r_recv_cnt[1:0] +: 8] = mem.mem_data;
            w_recv_cnt_d                         = r_recv_cnt + 3'd1;
        end

        unique case (r_state)
            StReq: begin
                if (r_run) begin
                    if (r_issue_cnt == 3'd0 && w_hit) begin
                        w_state_d = StPresent;
                        w_pc_d    = r_fetch_pc;
                        w_inst_d  = w_hit_data;
                        w_valid_d = 1'b1;
                    end else begin
                        w_mem_req = 1'b1;
                        if (mem.mem_gnt) begin
                            w_issue_cnt_d = r_issue_cnt + 3'd1;
                            w_pending_d   = 1'b1;
                            if (r_issue_cnt == 3'd3) begin
                                w_state_d = StDrain;
                            end
                        end
                    end
                end
            end
            StDrain: begin
                if (r_pending && r_recv_cnt == 3'd3) begin
                    w_state_d = StPresent;
                    w_pc_d    = r_fetch_pc;
                    w_inst_d  = w_inst_buf_d;
                    w_valid_d = 1'b1;
                    w_fill    = 1'b1;
                end
            end
            StPresent: begin
                if (!stall_i) begin
                    w_state_d     = StReq;
                    w_fetch_pc_d  = r_fetch_pc + 32'd4;
                    w_issue_cnt_d = 3'd0;
                    w_recv_cnt_d  = 3'd0;
                    w_valid_d     = 1'b0;
                end
            end
            default: w_state_d = StReq;
        endcase

        // Redirect overrides everything, including a consume or cache hit in the same cycle.
        if (w_redirect) begin
            w_state_d     = StReq;
            w_fetch_pc_d  = {branch_addr_i[31:2], 2'b00};
            w_issue_cnt_d = 3'd0;
            w_recv_cnt_d  = 3'd0;
            w_pending_d   = 1'b0;
            w_pc_d        = r_pc;
            w_inst_d      = r_inst;
            w_valid_d     = 1'b0;
            w_fill        = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= StReq;
            r_fetch_pc  <= '0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_pending   <= 1'b0;
            r_run       <= 1'b0;
            r_inst_buf  <= '0;
            r_pc        <= '0;
            r_inst      <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_fetch_pc  <= w_fetch_pc_d;
            r_issue_cnt <= w_issue_cnt_d;
            r_recv_cnt  <= w_recv_cnt_d;
            r_pending   <= w_pending_d;
            r_run       <= 1'b1;
            r_inst_buf  <= w_inst_buf_d;
            r_pc        <= w_pc_d;
            r_inst      <= w_inst_d;
            r_valid     <= w_valid_d;
        end
    end

    assign mem.mem_req  = w_mem_req;
    assign mem.mem_addr = w_mem_addr;
    assign pc_o         = r_pc;
    assign inst_o       = r_inst;
    assign inst_valid_o = r_valid;
endmodule

// File: tb/tb_stage_if.sv
// Directed self-checking bench for stage_if with a byte-wide memory model.
// Cache-dependent expectations switch on ICACHE_EN.
module tb_stage_if;
    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        branch_enable_i;
    logic [31:0] branch_addr_i;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    int          n_checks;
    int          n_errors;

`ifdef ICACHE_EN
    localparam bit ExpHit = 1'b1;
`else
    localparam bit ExpHit = 1'b0;
`endif

    stage_if_if bus ();

    stage_if #(
        .ICACHE_ENTRIES(64)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall_i),
        .branch_enable_i(branch_enable_i),
        .branch_addr_i  (branch_addr_i),
        .mem            (bus),
        .pc_o           (pc_o),
        .inst_o         (inst_o),
        .inst_valid_o   (inst_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] byte_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: byte_at = 8'h13;
            32'h0000_0001: byte_at = 8'h05;
            32'h0000_0002: byte_at = 8'h10;
            32'h0000_0003: byte_at = 8'h00;
            32'h0000_1010: byte_at = 8'h6f;
            32'h0000_1011: byte_at = 8'h00;
            32'h0000_1012: byte_at = 8'h00;
            32'h0000_1013: byte_at = 8'h00;
            default:       byte_at = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // Memory answers one cycle after a granted request; ungranted cycles return junk.
    always @(posedge clk) begin
        if (bus.mem_req && bus.mem_gnt) bus.mem_data <= byte_at(bus.mem_addr);
        else                            bus.mem_data <= 8'hEE;
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic start_at(input logic [31:0] a);
        branch_enable_i = 1'b1;
        branch_addr_i   = a;
        tick();
        branch_enable_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, pc_o, inst_o, inst_valid_o} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL reset_values: req=%0b addr=%h pc=%h inst=%h valid=%0b, want all zero",
                     bus.mem_req, bus.mem_addr, pc_o, inst_o, inst_valid_o);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0}) begin
            n_errors++;
            $display("FAIL reset_first_req: req=%0b addr=%h, want 1/00000000", bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_fetch;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'(i)}) begin
                n_errors++;
                $display("FAIL fetch_addr%0d: req=%0b addr=%h, want 1/%h", i, bus.mem_req, bus.mem_addr, i);
            end
            tick();
        end
        n_checks++;
        if ({bus.mem_req, inst_valid_o} !== 2'b00) begin
            n_errors++;
            $display("FAIL fetch_drain: req=%0b valid=%0b, want 0/0", bus.mem_req, inst_valid_o);
        end
        tick();
        n_checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h0, 32'h0010_0513}) begin
            n_errors++;
            $display("FAIL fetch_present: valid=%0b pc=%h inst=%h, want 1/00000000/00100513",
                     inst_valid_o, pc_o, inst_o);
        end
        tick();
        n_checks++;
        if ({inst_valid_o, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h4}) begin
            n_errors++;
            $display("FAIL fetch_next: valid=%0b req=%0b addr=%h, want 0/1/00000004",
                     inst_valid_o, bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_gnt_stall;
        start_at(32'h0000_2020);
        tick();
        tick();
        bus.mem_gnt = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) bus.mem_gnt = 1'b1;
            n_checks++;
            if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0000_2022}) begin
                n_errors++;
                $display("FAIL gnt_hold%0d: req=%0b addr=%h, want 1/00002022", i, bus.mem_req, bus.mem_addr);
            end
            tick();
        end
        n_checks++;
        if (bus.mem_addr !== 32'h0000_2023) begin
            n_errors++;
            $display("FAIL gnt_byte3: addr=%h, want 00002023", bus.mem_addr);
        end
        tick();
        n_checks++;
        if (inst_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL gnt_early_valid: valid=%0b, want 0", inst_valid_o);
        end
        tick();
        n_checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h0000_2020, 32'h7978_7B7A}) begin
            n_errors++;
            $display("FAIL gnt_present: valid=%0b pc=%h inst=%h, want 1/00002020/79787b7a",
                     inst_valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_stall;
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if ({inst_valid_o, pc_o, inst_o, bus.mem_req} !== {1'b1, 32'h0000_2020, 32'h7978_7B7A, 1'b0}) begin
                n_errors++;
                $display("FAIL stall_hold%0d: valid=%0b pc=%h inst=%h req=%0b, want 1/00002020/79787b7a/0",
                         k, inst_valid_o, pc_o, inst_o, bus.mem_req);
            end
            stall_i         = (k < 4);
            branch_enable_i = (k == 1);
            branch_addr_i   = 32'h0000_5000;
            tick();
        end
        n_checks++;
        if ({inst_valid_o, bus.mem_req, bus.mem_addr} !== {1'b0, 1'b1, 32'h0000_2024}) begin
            n_errors++;
            $display("FAIL stall_release: valid=%0b req=%0b addr=%h, want 0/1/00002024",
                     inst_valid_o, bus.mem_req, bus.mem_addr);
        end
    endtask

    task automatic test_redirect;
        tick();
        tick();
        start_at(32'h0000_1012);
        n_checks++;
        if ({bus.mem_req, bus.mem_addr} !== {1'b1, 32'h0000_1010}) begin
            n_errors++;
            $display("FAIL redirect_addr: req=%0b addr=%h, want 1/00001010", bus.mem_req, bus.mem_addr);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (inst_valid_o !== 1'b0) begin
                n_errors++;
                $display("FAIL redirect_no_valid%0d: valid=%0b pc=%h, want valid 0", i, inst_valid_o, pc_o);
            end
            tick();
        end
        n_checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h0000_1010, 32'h0000_006f}) begin
            n_errors++;
            $display("FAIL redirect_present: valid=%0b pc=%h inst=%h, want 1/00001010/0000006f",
                     inst_valid_o, pc_o, inst_o);
        end
    endtask

    task automatic test_wrap;
        // Redirect coincides with consume: target wins over pc+4.
        start_at(32'hFFFF_FFFE);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({bus.mem_req, bus.mem_addr, inst_valid_o} !== {1'b1, 32'hFFFF_FFFC + 32'(i), 1'b0}) begin
                n_errors++;
                $display("FAIL wrap_addr%0d: req=%0b addr=%h valid=%0b, want 1/%h/0",
                         i, bus.mem_req, bus.mem_addr, inst_valid_o, 32'hFFFF_FFFC + 32'(i));
            end
            tick();
        end
        tick();
        n_checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'hFFFF_FFFC, 32'hA5A4_A7A6}) begin
            n_errors++;
            $display("FAIL wrap_present: valid=%0b pc=%h inst=%h, want 1/fffffffc/a5a4a7a6",
                     inst_valid_o, pc_o, inst_o);
        end
        tick();
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, inst_valid_o} !== {~ExpHit, 32'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL wrap_next: req=%0b addr=%h valid=%0b, want %0b/00000000/0",
                     bus.mem_req, bus.mem_addr, inst_valid_o, ~ExpHit);
        end
    endtask

    task automatic test_reset_mid;
        start_at(32'h0000_3000);
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if ({bus.mem_req, bus.mem_addr, pc_o, inst_o, inst_valid_o} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            n_errors++;
            $display("FAIL midreset_values: req=%0b addr=%h pc=%h inst=%h valid=%0b, want all zero",
                     bus.mem_req, bus.mem_addr, pc_o, inst_o, inst_valid_o);
        end
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if (inst_valid_o !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_early_valid: valid=%0b, want 0", inst_valid_o);
        end
        tick();
        n_checks++;
        if ({inst_valid_o, pc_o, inst_o} !== {1'b1, 32'h0, 32'h0010_0513}) begin
            n_errors++;
            $display("FAIL midreset_present: valid=%0b pc=%h inst=%h, want 1/00000000/00100513",
                     inst_valid_o, pc_o, inst_o);
        end
    endtask

`ifdef ICACHE_EN
    task automatic test_icache;
        tick();
        start_at(32'h0000_0000);
        n_checks++;
        if ({bus.mem_req, inst_valid_o} !== 2'b00) begin
            n_errors++;
            $display("FAIL icache_hit_cycle: req=%0b valid=%0b, want 0/0", bus.mem_req, inst_valid_o);
        end
        tick();
        n_checks++;
        if ({inst_valid_o, pc_o, inst_o, bus.mem_req} !== {1'b1, 32'h0, 32'h0010_0513, 1'b0}) begin
            n_errors++;
            $display("FAIL icache_present: valid=%0b pc=%h inst=%h req=%0b, want 1/00000000/00100513/0",
                     inst_valid_o, pc_o, inst_o, bus.mem_req);
        end
    endtask
`endif

    initial begin
        n_checks        = 0;
        n_errors        = 0;
        stall_i         = 1'b0;
        branch_enable_i = 1'b0;
        branch_addr_i   = '0;
        bus.mem_gnt     = 1'b1;
        test_reset();
        test_fetch();
        test_gnt_stall();
        test_stall();
        test_redirect();
        test_wrap();
        test_reset_mid();
`ifdef ICACHE_EN
        test_icache();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1);
    end
endmodule
